// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } spi_state_t;

   // Opcodes carried in rx_data[9:8]; forwarded to the RAM unchecked.
   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   localparam int FRAME_BITS = 10;
   localparam int TX_BITS    = 8;

endpackage

// File: rtl/spi_shift_reg.sv
// Serial-in/parallel-out receive shifter, parallel-in/serial-out transmit
// shifter and a shared bit counter. All sequencing is owned by the caller.
module spi_shift_reg #(
   parameter int RX_W  = 10,
   parameter int TX_W  = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             cnt_clr,
   input  logic             cnt_inc,
   input  logic             rx_en,
   input  logic             sin,
   input  logic             tx_load,
   input  logic [TX_W-1:0]  tx_pin,
   input  logic             tx_en,
   output logic [RX_W-1:0]  rx_word,
   output logic             sout,
   output logic [CNT_W-1:0] cnt
);

   logic [RX_W-2:0] rx_sr;
   logic [TX_W-1:0] tx_sr;

   // The word that would be complete if the current bit is the last one,
   // so the caller can register it on the same edge that samples it.
   assign rx_word = {rx_sr, sin};
   assign sout    = tx_sr[TX_W-1];

   // Counter and both shifters; clr wipes everything for a fresh frame.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         rx_sr <= '0;
         tx_sr <= '0;
         cnt   <= '0;
      end else begin
         if (cnt_clr)      cnt <= '0;
         else if (cnt_inc) cnt <= cnt + 1'b1;
         if (rx_en)        rx_sr <= rx_word[RX_W-2:0];
         if (tx_load)      tx_sr <= tx_pin;
         else if (tx_en)   tx_sr <= {tx_sr[TX_W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end: deserialises MOSI command frames for the RAM and
// serialises RAM read data back onto MISO. SPI clock is assumed equal to clk.
module spi_slave_ctrl
   import spi_pkg::*;
#(
   parameter int MEM_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 SS_n,
   input  logic                 MOSI,
   output logic                 MISO,
   output logic [MEM_WIDTH+1:0] rx_data,
   output logic                 rx_valid,
   input  logic [MEM_WIDTH-1:0] tx_data,
   input  logic                 tx_valid
);

   localparam int RX_W  = MEM_WIDTH + 2;
   localparam int TX_W  = MEM_WIDTH;
   localparam int CNT_W = $clog2(RX_W + 1);

   spi_state_t       state;
   logic             rd_addr_seen;
   logic             rx_done;   // 10-bit payload received this frame
   logic             tx_busy;   // MISO transmit in progress
   logic             tx_done;   // transmit finished; idle until SS_n rises

   logic             clr, cnt_clr, cnt_inc, rx_en, last_bit, tx_load, tx_en, active;
   logic [RX_W-1:0]  rx_word;
   logic             sout;
   logic [CNT_W-1:0] cnt;

   // Datapath strobes derived from the current state and frame progress.
   always_comb begin
      active   = !SS_n && (state == WRITE || state == READ_ADD || state == READ_DATA);
      clr      = (state == IDLE) || SS_n;
      rx_en    = active && !rx_done;
      last_bit = rx_en && (cnt == CNT_W'(RX_W - 1));
      tx_load  = active && (state == READ_DATA) && rx_done && !tx_busy && !tx_done && tx_valid;
      tx_en    = active && (state == READ_DATA) && tx_busy && (cnt < CNT_W'(TX_W));
      cnt_clr  = last_bit;
      cnt_inc  = rx_en || tx_load || tx_en;
   end

   // Bit 7 goes straight to MISO on the capture edge; the shifter holds the
   // remaining bits pre-shifted so its MSB is always the next bit to drive.
   spi_shift_reg #(.RX_W(RX_W), .TX_W(TX_W), .CNT_W(CNT_W)) u_shift (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .cnt_clr (cnt_clr),
      .cnt_inc (cnt_inc),
      .rx_en   (rx_en),
      .sin     (MOSI),
      .tx_load (tx_load),
      .tx_pin  ({tx_data[TX_W-2:0], 1'b0}),
      .tx_en   (tx_en),
      .rx_word (rx_word),
      .sout    (sout),
      .cnt     (cnt)
   );

   // Frame FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         MISO         <= 1'b0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rd_addr_seen <= 1'b0;
         rx_done      <= 1'b0;
         tx_busy      <= 1'b0;
         tx_done      <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (state == IDLE || SS_n) begin
            // Idle or frame aborted: everything but rd_addr_seen restarts.
            MISO    <= 1'b0;
            rx_done <= 1'b0;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
            state   <= (state == IDLE && !SS_n) ? CHK_CMD : IDLE;
         end else if (state == CHK_CMD) begin
            if (!MOSI)             state <= WRITE;
            else if (rd_addr_seen) state <= READ_DATA;
            else                   state <= READ_ADD;
         end else if (last_bit) begin
            rx_data  <= rx_word;
            rx_valid <= 1'b1;
            rx_done  <= 1'b1;
            if (state == READ_ADD) rd_addr_seen <= 1'b1;
         end else if (tx_load) begin
            MISO    <= tx_data[TX_W-1];
            tx_busy <= 1'b1;
         end else if (tx_en) begin
            MISO <= sout;
            if (cnt == CNT_W'(TX_W - 1)) rd_addr_seen <= 1'b0;
         end else if (tx_busy) begin
            MISO    <= 1'b0;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl. The driver pushes expected command words
// into a queue and publishes the expected per-cycle MISO/rx_valid; a monitor
// on the falling edge compares what the DUT presents.
module tb_spi_slave_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       SS_n = 1'b1;
   logic       MOSI = 1'b0;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;

   logic [9:0] exp_q[$];
   logic       exp_rxv  = 1'b0;
   logic       exp_miso = 1'b0;
   logic       mon_en   = 1'b0;
   int         n_cmp = 0;
   int         n_bad = 0;

   spi_slave_ctrl #(.MEM_WIDTH(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: strobe and MISO every cycle, data on each rx_valid pulse.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("rx_valid", {31'd0, rx_valid}, {31'd0, exp_rxv});
         chk("MISO", {31'd0, MISO}, {31'd0, exp_miso});
         if (rx_valid) begin
            if (exp_q.size() == 0) chk("rx_unexpected", 32'd1, 32'd0);
            else chk("rx_data", {22'd0, rx_data}, {22'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One SS_n-low transaction. nbits<10 aborts early; txv drives tx_valid at
   // t13 with tx_d; exp_tx says whether MISO should carry tx_d; rst_bit>=0
   // pulls reset during the cycle MISO carries that bit.
   task automatic frame(input bit sel, input logic [9:0] w, input int nbits,
                        input bit txv, input logic [7:0] tx_d, input bit exp_tx,
                        input int rst_bit);
      SS_n = 1'b0; MOSI = 1'b0; tick();          // t0
      MOSI = sel; tick();                        // t1 select bit
      for (int i = 0; i < nbits; i++) begin      // t2..t11
         MOSI = w[9-i]; tick();
      end
      MOSI = 1'b0;
      if (nbits == 10) begin
         exp_rxv = 1'b1; exp_q.push_back(w); tick();   // t12
         exp_rxv = 1'b0;
         tx_valid = txv; tx_data = tx_d; tick();        // t13
         tx_valid = 1'b0;
         for (int i = 7; i >= 0; i--) begin             // t14..t21
            exp_miso = exp_tx ? tx_d[i] : 1'b0;
            if (i == rst_bit) begin
               rst_n = 1'b0; tick();
               rst_n = 1'b1; exp_miso = 1'b0;
               break;
            end
            tick();
         end
         exp_miso = 1'b0;
      end
      SS_n = 1'b1; tick();
   endtask

   initial begin
      tick(); tick();
      chk("reset_MISO", {31'd0, MISO}, 32'd0);
      chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("reset_rx_data", {22'd0, rx_data}, 32'd0);
      rst_n = 1'b1;
      mon_en = 1'b1;
      tick();

      // Write address, write data.
      frame(1'b0, 10'h03A, 10, 1'b0, 8'h00, 1'b0, -1);
      frame(1'b0, 10'h1C5, 10, 1'b0, 8'h00, 1'b0, -1);
      // Read address (tx_valid ignored there), then read data returns C5.
      frame(1'b1, 10'h23A, 10, 1'b1, 8'hFF, 1'b0, -1);
      frame(1'b1, 10'h300, 10, 1'b1, 8'hC5, 1'b1, -1);
      // rd_addr_seen cleared by the transmit: select=1 is a read address again.
      frame(1'b1, 10'h255, 10, 1'b1, 8'hA5, 1'b0, -1);
      // Abort after 5 payload bits, then a full frame.
      frame(1'b0, 10'h0AA, 5, 1'b0, 8'h00, 1'b0, -1);
      frame(1'b0, 10'h2F0, 10, 1'b0, 8'h00, 1'b0, -1);
      // Back-to-back writes with one SS_n-high cycle between.
      frame(1'b0, 10'h155, 10, 1'b0, 8'h00, 1'b0, -1);
      frame(1'b0, 10'h0AB, 10, 1'b0, 8'h00, 1'b0, -1);
      // Read data (rd_addr_seen set by 0x255 frame), reset during bit 3.
      frame(1'b1, 10'h3FF, 10, 1'b1, 8'h96, 1'b1, 3);
      // Reset cleared rd_addr_seen: select=1 decodes as read address, no MISO.
      frame(1'b1, 10'h211, 10, 1'b1, 8'h5A, 1'b0, -1);
      tick(); tick();
      mon_en = 1'b0;
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
SPI slave front end that sits directly upstream of the single-port RAM and feeds it.
- Deserialises MOSI frames into 10-bit command words (rx_data/rx_valid) for the RAM.
- Serialises the RAM's 8-bit read data (tx_data/tx_valid) back onto MISO.
- All logic runs in the system clk domain; the SPI clock is assumed equal to clk, with one bit per clk cycle.

Parameters:
MEM_WIDTH, 8, payload data width; rx_data is MEM_WIDTH+2 bits and tx_data is MEM_WIDTH bits.

Ports:
clk  input  1  system clock; all logic on posedge.
rst_n  input  1  reset, synchronous, active-low; clock clk.
SS_n  input  1  slave select, active-low; frames a transaction.
MOSI  input  1  serial data in, MSB first.
MISO  output  1  serial data out, MSB first.
rx_data  output  MEM_WIDTH+2  command word to RAM: [9:8] opcode, [7:0] address/data.
rx_valid  output  1  one-cycle strobe; rx_data is valid.
tx_data  input  MEM_WIDTH  read data from RAM.
tx_valid  input  1  tx_data is valid; sampled only in READ_DATA.

Behaviour:
- Reset (rst_n=0 at posedge) sets:
  - state=IDLE; MISO=0; rx_data=0; rx_valid=0.
  - bit counter=0; rd_addr_seen=0; tx shift register=0.
  - Reset overrides all other activity, including mid-frame.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 -> CHK_CMD next cycle; otherwise stay.
- CHK_CMD: samples MOSI as a select bit. The select bit is not part of rx_data.
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_seen=0 -> READ_ADD.
  - MOSI=1 and rd_addr_seen=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA receive phase:
  - Shift in MOSI for 10 consecutive cycles, MSB first.
  - The counter counts 0..9.
  - On the edge sampling bit 9 (counter=9): register rx_data=shifted word and assert rx_valid.
  - rx_valid is high for exactly the one following cycle; the counter then stops.
  - Further MOSI bits are ignored until SS_n rises.
- READ_ADD: at frame completion, set rd_addr_seen=1.
- READ_DATA transmit phase:
  - After the 10-bit receive, wait for tx_valid=1 and capture tx_data on that edge.
  - On the following cycles drive MISO = captured bits 7..0, one per cycle, over 8 cycles.
  - Then MISO=0.
  - Clear rd_addr_seen when the 8th bit is driven.
  - tx_valid outside this wait window is ignored.
- MISO is 0 in every state except the READ_DATA transmit window.
- SS_n=1 in any non-IDLE state:
  - Go to IDLE next cycle and clear counters.
  - A partial frame (<10 bits) never produces rx_valid.
  - rd_addr_seen keeps its value unless the READ_DATA transmit has completed.
- The opcode in rx_data[9:8] is forwarded unchecked; the master is responsible for consistency with the select bit.
- Latency: SS_n fall at cycle t0 gives:
  - CHK_CMD at t1;
  - payload bits at t2..t11;
  - rx_valid high during t12;
  - RAM tx_valid during t13;
  - MISO bit7 during t14, through bit0 during t21.

Decomposition:
- Package spi_pkg holds:
  - state enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA);
  - opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11;
  - FRAME_BITS=10 and TX_BITS=8.
- One sub-module: spi_shift_reg, a parameterised serial-in/parallel-out plus parallel-in/serial-out shifter with a counter.
- The FSM stays in spi_slave_ctrl.

Test Plan:
- Write address: SS_n low, select=0, MOSI 00_0011_1010 -> rx_data=10'h03A, rx_valid high for 1 cycle at t12, MISO=0 throughout.
- Write data: select=0, MOSI 01_1100_0101 -> rx_data=10'h1C5, one rx_valid pulse. With the RAM attached, mem[0x3A]=0xC5.
- Read address then read data:
  - select=1, MOSI 10_0011_1010 -> rx_data=10'h23A, rd_addr_seen=1.
  - New frame, select=1, MOSI 11_0000_0000 -> rx_data=10'h300.
  - tx_valid with tx_data=8'hC5 -> MISO sequence 1,1,0,0,0,1,0,1 during t14..t21, then rd_addr_seen=0.
- Abort: SS_n rises after 5 payload bits in WRITE -> no rx_valid, state IDLE next cycle. The next full frame is decoded correctly.
- Reset mid-transmit: rst_n=0 during the MISO bit 3 cycle -> next cycle MISO=0, state IDLE, rd_addr_seen=0, rx_valid=0.
- Back-to-back frames: SS_n high for 1 cycle between two write frames -> two rx_valid pulses with correct data each, no extra pulse.
